// File: rtl/alarm_pkg.sv
// Shared types and constants for the stopwatch alarm controller.
package alarm_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic {
      ALARM_IDLE = 1'b0,
      ALARM_RING = 1'b1
   } alarm_state_e;

   // Bits needed to hold values 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/alarm_blinker.sv
// Blink phase generator: phase starts high on a ring start/retrigger and
// toggles every BLINK_HALF cycles while the ring stays active.
module alarm_blinker
   import alarm_pkg::*;
#(
   parameter int BLINK_HALF = 10
) (
   input  logic clk_dvid,
   input  logic rst_n,
   input  logic start,
   input  logic active,
   output logic phase
);

   localparam int HALF_W = cnt_width(BLINK_HALF);
   localparam logic [HALF_W-1:0] HALF_LOAD = HALF_W'(BLINK_HALF - 1);

   logic [HALF_W-1:0] half_q;
   logic              phase_q;

   // Half-period down-counter; phase flips at terminal count.
   always_ff @(posedge clk_dvid or negedge rst_n) begin
      if (!rst_n) begin
         half_q  <= '0;
         phase_q <= 1'b0;
      end else if (start) begin
         half_q  <= HALF_LOAD;
         phase_q <= 1'b1;
      end else if (active) begin
         if (half_q == '0) begin
            half_q  <= HALF_LOAD;
            phase_q <= ~phase_q;
         end else begin
            half_q  <= half_q - HALF_W'(1);
         end
      end else begin
         half_q  <= '0;
         phase_q <= 1'b0;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: rings the LED for ON_CYCLES cycles on each rising match
// of the BCD display value against a programmable target.
// Optional blinking LED is built only when ALARM_BLINK_EN is defined.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int ON_CYCLES  = 100,
   parameter int BLINK_HALF = 10,
   parameter int CNT_W      = 8
) (
   input  logic                          clk_dvid,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] target,
   input  logic                          ack,
   input  logic                          blink_mode,
   output logic                          led,
   output logic                          ringing,
   output logic [CNT_W-1:0]              fire_cnt
);

   localparam int DUR_W = cnt_width(ON_CYCLES);
   localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(ON_CYCLES - 1);

   alarm_state_e     state_q;
   logic [DUR_W-1:0] dur_q;
   logic [CNT_W-1:0] fire_q;
   logic             ringing_q;
   logic             match;
   logic             match_q;
   logic             rise;
   logic             fire;

   // Raw nibble equality; invalid BCD codes still compare.
   assign match = (digits == target);
   assign rise  = match & ~match_q;
   assign fire  = en & rise;

   // Match history, tracked regardless of state or enable.
   always_ff @(posedge clk_dvid or negedge rst_n) begin
      if (!rst_n) match_q <= 1'b0;
      else        match_q <= match;
   end

   // Ring FSM with duration timer and saturating fire counter; a new rise
   // wins over ack and expiry in the same cycle.
   always_ff @(posedge clk_dvid or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ALARM_IDLE;
         dur_q     <= '0;
         fire_q    <= '0;
         ringing_q <= 1'b0;
      end else if (fire) begin
         state_q   <= ALARM_RING;
         ringing_q <= 1'b1;
         dur_q     <= DUR_LOAD;
         if (fire_q != {CNT_W{1'b1}}) fire_q <= fire_q + CNT_W'(1);
      end else if (state_q == ALARM_RING) begin
         if (!en || ack || dur_q == '0) begin
            state_q   <= ALARM_IDLE;
            ringing_q <= 1'b0;
            dur_q     <= '0;
         end else begin
            dur_q     <= dur_q - DUR_W'(1);
         end
      end
   end

   assign ringing  = ringing_q;
   assign fire_cnt = fire_q;

`ifdef ALARM_BLINK_EN
   logic phase;
   logic blink_q;

   // Mode is registered so the LED never follows an input combinationally.
   always_ff @(posedge clk_dvid or negedge rst_n) begin
      if (!rst_n) blink_q <= 1'b0;
      else        blink_q <= blink_mode;
   end

   alarm_blinker #(
      .BLINK_HALF (BLINK_HALF)
   ) u_blinker (
      .clk_dvid (clk_dvid),
      .rst_n    (rst_n),
      .start    (fire),
      .active   (state_q == ALARM_RING),
      .phase    (phase)
   );

   assign led = ringing_q & (~blink_q | phase);
`else
   logic unused_blink;
   assign unused_blink = blink_mode ^ BLINK_HALF[0];
   assign led = ringing_q;
`endif

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Parametrised alarm controller for the stopwatch datapath. It compares an N-digit BCD display value against a programmable target each clock. On the first cycle of a match it drives an alarm LED for a fixed number of cycles. The LED output is steady, or blinking when that feature is compiled in. The block sits beside the digit counters and display driver, and is the configurable successor to the fixed 9999 alarm.

## Interface
- NUM_DIGITS, 4: number of BCD digits compared.
- ON_CYCLES, 100: LED-active duration in clk_dvid cycles, ≥1.
- BLINK_HALF, 10: blink half-period in cycles, ≥1; used only with ALARM_BLINK_EN.
- CNT_W, 8: width of the saturating alarm-event counter.
- clk_dvid, input, 1: divided system clock; all logic on its rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: alarm enable.
- digits, input, 4*NUM_DIGITS: current display value; digit 0 is in bits [3:0].
- target, input, 4*NUM_DIGITS: alarm compare value.
- ack, input, 1: user acknowledge; ends an active ring early.
- blink_mode, input, 1: 1 selects blinking LED.
- led, output, 1: alarm LED.
- ringing, output, 1: high while state is RING.
- fire_cnt, output, CNT_W: number of alarms fired; saturates at all-ones.

## Operation
- match = (digits == target): raw 4-bit equality per digit, with no BCD validity check.
- match_q is a register tracking match every cycle, regardless of state or en.
- rise = match & ~match_q. A held match never refires.
- States are IDLE and RING.
- IDLE → RING when en & rise. The duration counter loads ON_CYCLES-1, and fire_cnt increments unless saturated.
- In RING, the counter decrements each cycle.
- RING → IDLE when the counter is 0, when ack=1, or when en=0.
- Retrigger: en & rise in RING reloads the counter to ON_CYCLES-1 and increments fire_cnt. This takes priority over ack and over expiry in the same cycle.
- en=0 forces IDLE next cycle and blocks rise. Re-enabling while the match persists does not fire.
- The counter width is $clog2(ON_CYCLES+1), and the counter never wraps below 0.
- Steady mode: led = ringing.
- Blink mode: the LED phase register is set to 1 on entry or retrigger, and toggles every BLINK_HALF cycles while in RING. led = ringing & phase.
- Changing target mid-ring does not affect the current ring. It affects only match and rise.

## Timing
- Reset values: state=IDLE, led=0, ringing=0, fire_cnt=0, match_q=0, counter=0, phase=0.
- Reset is asynchronous assert and synchronous-edge release; it aborts any ring immediately.
- Latency: the digits/target match is first presented at edge k (rise evaluated at edge k). ringing and led go high after edge k, and stay high for exactly ON_CYCLES cycles.
- If rise is seen on the first edge after reset release and the match existed at reset, it fires, because match_q=0 at reset.
- ack at edge k drops led/ringing after edge k. ack in IDLE has no effect.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- Macro ALARM_BLINK_EN.
- Defined: blink_mode is honoured, and the phase counter and phase register exist.
- Undefined: no blink logic is built, blink_mode is ignored, and led = ringing always. BLINK_HALF is accepted but unused.

## Structure
- Package alarm_pkg holds:
  - the state typedef (ALARM_IDLE, ALARM_RING);
  - the BCD digit width constant DIGIT_W=4;
  - the helper function computing counter width.
- One sub-module, alarm_blinker: phase counter plus phase register, with inputs start, active and BLINK_HALF, and output phase. It is instantiated only under ALARM_BLINK_EN.
- The compare, edge detection, FSM, duration counter and fire counter stay in alarm_ctrl.

## Test plan
- Defaults, en=1, target=16'h9999, digits step 16'h9998→16'h9999 and hold → led high exactly 100 cycles starting one cycle after the match, fire_cnt=1, no refire while held.
- Match at cycle 0, second rising match at cycle 50 (via 16'h9998 for one cycle) → ring extends to cycle 150, fire_cnt=2.
- ack pulse at cycle 30 of ring → led=0 next cycle. ack coincident with a new rise → ring restarts at 100, fire_cnt increments.
- en=0 during match edge → no ring, fire_cnt unchanged. en 0→1 while still matching → no fire. en dropped mid-ring → led=0 next cycle.
- ALARM_BLINK_EN defined, blink_mode=1, BLINK_HALF=10 → led pattern 10 high / 10 low ×5 over 100 cycles. Same stimulus without the macro → led steady 100 cycles.
- CNT_W=2, 5 alarms → fire_cnt saturates at 3. rst_n low mid-ring → all outputs 0 immediately.
